// File: rtl/iob_master_pkg.sv
// rtl/iob_master_pkg.sv - shared state encoding and default timing constants for iob_master
package iob_master_pkg;

    localparam int EDIV_DEF = 10;
    localparam int TMO_DEF  = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_STRB,
        ST_WAIT,
        ST_VMA,
        ST_TERM,
        ST_RECOV
    } iob_state_e;

endpackage

// File: rtl/iob_master_if.sv
// rtl/iob_master_if.sv - FSB-side request and 68k-style peripheral bus signals of iob_master
interface iob_master_if;

    logic IOREQ;
    logic IORW;
    logic IOL;
    logic IOU;
    logic IOACT;
    logic IOBERR;
    logic nDTACK;
    logic nVPA;
    logic nBERR;
    logic nAS;
    logic nLDS;
    logic nUDS;
    logic nVMA;
    logic E;
    logic nDoutOE;
    logic nDinLE;

    modport master (
        input  IOREQ, IORW, IOL, IOU, nDTACK, nVPA, nBERR,
        output IOACT, IOBERR, nAS, nLDS, nUDS, nVMA, E, nDoutOE, nDinLE
    );

    modport slave (
        output IOREQ, IORW, IOL, IOU, nDTACK, nVPA, nBERR,
        input  IOACT, IOBERR, nAS, nLDS, nUDS, nVMA, E, nDoutOE, nDinLE
    );

endinterface

// File: rtl/iob_sync.sv
// rtl/iob_sync.sv - two-flop synchronizer for one asynchronous peripheral input
module iob_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic nRES,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/iob_master.sv
// rtl/iob_master.sv - 68000-style peripheral bus cycle master with 6800 E/VMA support
module iob_master
    import iob_master_pkg::*;
#(
    parameter int EDIV = EDIV_DEF,
    parameter int TMO  = TMO_DEF
) (
    input  logic         CLK,
    input  logic         nRES,
    iob_master_if.master bus
);

    localparam int EW = $clog2(EDIV);
    localparam int TW = $clog2(TMO + 1);
    localparam logic [EW-1:0] ECNT_LAST = EW'(EDIV - 1);
    localparam logic [EW-1:0] ECNT_EHI  = EW'(EDIV - 4);
    localparam logic [EW-1:0] ECNT_VMA  = EW'(3);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO - 1);

    logic dtack_n_s, vpa_n_s, berr_n_s;
    logic dtack_s, vpa_s, berr_s;

    iob_sync u_sync_dtack (.CLK(CLK), .nRES(nRES), .d_i(bus.nDTACK), .q_o(dtack_n_s));
    iob_sync u_sync_vpa   (.CLK(CLK), .nRES(nRES), .d_i(bus.nVPA),   .q_o(vpa_n_s));
    iob_sync u_sync_berr  (.CLK(CLK), .nRES(nRES), .d_i(bus.nBERR),  .q_o(berr_n_s));

    assign dtack_s = ~dtack_n_s;
    assign vpa_s   = ~vpa_n_s;
    assign berr_s  = ~berr_n_s;

    // E is registered from the next count so it is high exactly while Ecnt is in the top four slots
    logic [EW-1:0] ecnt_q, ecnt_d;
    logic          e_q;

    assign ecnt_d = (ecnt_q == ECNT_LAST) ? '0 : ecnt_q + EW'(1);

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            ecnt_q <= '0;
            e_q    <= 1'b0;
        end else begin
            ecnt_q <= ecnt_d;
            e_q    <= (ecnt_d >= ECNT_EHI);
        end
    end

    iob_state_e    state_q, state_d;
    logic          rd_q, rd_d;
    logic          iol_q, iol_d;
    logic          iou_q, iou_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ioact_q, ioact_d;
    logic          ioberr_q, ioberr_d;
    logic          nas_q, nas_d;
    logic          nlds_q, nlds_d;
    logic          nuds_q, nuds_d;
    logic          nvma_q, nvma_d;
    logic          ndoutoe_q, ndoutoe_d;
    logic          ndinle_q, ndinle_d;

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state_q   <= ST_IDLE;
            rd_q      <= 1'b0;
            iol_q     <= 1'b0;
            iou_q     <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
            ioact_q   <= 1'b0;
            ioberr_q  <= 1'b0;
            nas_q     <= 1'b1;
            nlds_q    <= 1'b1;
            nuds_q    <= 1'b1;
            nvma_q    <= 1'b1;
            ndoutoe_q <= 1'b1;
            ndinle_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            iol_q     <= iol_d;
            iou_q     <= iou_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            ioact_q   <= ioact_d;
            ioberr_q  <= ioberr_d;
            nas_q     <= nas_d;
            nlds_q    <= nlds_d;
            nuds_q    <= nuds_d;
            nvma_q    <= nvma_d;
            ndoutoe_q <= ndoutoe_d;
            ndinle_q  <= ndinle_d;
        end
    end

    // Actions of a state are registered on its exit edge; IOBERR and nDinLE are single-cycle pulses
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        iol_d     = iol_q;
        iou_d     = iou_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        ioact_d   = ioact_q;
        ioberr_d  = 1'b0;
        nas_d     = nas_q;
        nlds_d    = nlds_q;
        nuds_d    = nuds_q;
        nvma_d    = nvma_q;
        ndoutoe_d = ndoutoe_q;
        ndinle_d  = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (bus.IOREQ) begin
                    state_d   = ST_ADDR;
                    ioact_d   = 1'b1;
                    rd_d      = bus.IORW;
                    iol_d     = bus.IOL;
                    iou_d     = bus.IOU;
                    err_d     = 1'b0;
                    ndoutoe_d = bus.IORW;
                end
            end
            ST_ADDR: begin
                nas_d = 1'b0;
                if (rd_q) begin
                    nlds_d = ~iol_q;
                    nuds_d = ~iou_q;
                end
                state_d = ST_STRB;
            end
            ST_STRB: begin
                if (!rd_q) begin
                    nlds_d = ~iol_q;
                    nuds_d = ~iou_q;
                end
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (berr_s) begin
                    err_d   = 1'b1;
                    state_d = ST_TERM;
                end else if (dtack_s) begin
                    state_d = ST_TERM;
                end else if (vpa_s) begin
                    state_d = ST_VMA;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_TERM;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_VMA: begin
                // nVMA itself records that the E-synchronous phase has begun
                if (nvma_q && ecnt_q == ECNT_VMA) begin
                    nvma_d = 1'b0;
                end else if (!nvma_q && ecnt_q == ECNT_LAST) begin
                    state_d = ST_TERM;
                end
            end
            ST_TERM: begin
                ndinle_d = ~rd_q;
                nas_d    = 1'b1;
                nlds_d   = 1'b1;
                nuds_d   = 1'b1;
                nvma_d   = 1'b1;
                ioberr_d = err_q;
                state_d  = ST_RECOV;
            end
            ST_RECOV: begin
                ndoutoe_d = 1'b1;
                nvma_d    = 1'b1;
                ioact_d   = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.IOACT   = ioact_q;
    assign bus.IOBERR  = ioberr_q;
    assign bus.nAS     = nas_q;
    assign bus.nLDS    = nlds_q;
    assign bus.nUDS    = nuds_q;
    assign bus.nVMA    = nvma_q;
    assign bus.E       = e_q;
    assign bus.nDoutOE = ndoutoe_q;
    assign bus.nDinLE  = ndinle_q;

endmodule
